// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: one-hot channel states, counter sizing, parameter limits.
// Holdoff support is selected by the PULSE_STRETCHER_HOLDOFF_EN macro in the channel module.
package pulse_stretcher_pkg;

   localparam int SIGNAL_WIDTH_MIN   = 1;
   localparam int SIGNAL_WIDTH_MAX   = 32;
   localparam int PULSE_WIDTH_MIN    = 1;
   localparam int PULSE_WIDTH_MAX    = 65535;
   localparam int HOLDOFF_CYCLES_MAX = 65535;

   // One-hot so that the ACTIVE bit can drive q directly.
   localparam int ACTIVE_BIT = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_ACTIVE  = 3'b010,
      ST_HOLDOFF = 3'b100
   } state_e;

   function automatic int cnt_width(input int pulse_width, input int holdoff_cycles);
      int m;
      m = 2;
      if (pulse_width > m) m = pulse_width;
      if (holdoff_cycles > m) m = holdoff_cycles;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/pulse_stretcher_ch.sv
// One pulse-stretcher channel: IDLE/ACTIVE/HOLDOFF FSM, down-counter, registered q/done/dropped.
// HOLDOFF logic exists only when PULSE_STRETCHER_HOLDOFF_EN is defined.
module pulse_stretcher_ch
   import pulse_stretcher_pkg::*;
#(
   parameter int PulseWidth    = 4,
   parameter int Retrigger     = 1,
   parameter int HoldoffCycles = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic trig,
   output logic q,
   output logic done,
   output logic dropped
);

   localparam int             CW        = cnt_width(PulseWidth, HoldoffCycles);
   localparam logic [CW-1:0]  PW_RELOAD = CW'(PulseWidth - 1);
   localparam bit             RETRIG    = (Retrigger != 0);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          dropped_q, dropped_d;
   logic          cnt_zero;
   logic          reload;

   assign cnt_zero = (cnt_q == '0);
   assign reload   = trig && RETRIG;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         dropped_q <= dropped_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (trig) begin
               state_d = ST_ACTIVE;
               cnt_d   = PW_RELOAD;
            end
         end
         ST_ACTIVE: begin
            // A retrigger wins over expiry, even on the final count.
            if (reload) begin
               cnt_d = PW_RELOAD;
            end else if (cnt_zero) begin
`ifdef PULSE_STRETCHER_HOLDOFF_EN
               if (HoldoffCycles > 0) begin
                  state_d = ST_HOLDOFF;
                  cnt_d   = CW'(HoldoffCycles - 1);
               end else begin
                  state_d = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
`ifdef PULSE_STRETCHER_HOLDOFF_EN
         ST_HOLDOFF: begin
            if (cnt_zero) state_d = ST_IDLE;
            else          cnt_d   = cnt_q - CW'(1);
         end
`endif
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      done_d    = (state_q == ST_ACTIVE) && cnt_zero && !reload;
      dropped_d = trig && (state_q == ST_ACTIVE) && !RETRIG;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
      if (trig && (state_q == ST_HOLDOFF)) dropped_d = 1'b1;
`endif
   end

   assign q       = state_q[ACTIVE_BIT];
   assign done    = done_q;
   assign dropped = dropped_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher: SignalWidth independent channels sharing clock and reset.
// Define PULSE_STRETCHER_HOLDOFF_EN to enable the post-pulse HOLDOFF recovery time.
module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int SignalWidth   = 1,
   parameter int PulseWidth    = 4,
   parameter int Retrigger     = 1,
   parameter int HoldoffCycles = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [SignalWidth-1:0] trig,
   output logic [SignalWidth-1:0] q,
   output logic [SignalWidth-1:0] done,
   output logic [SignalWidth-1:0] dropped
);

   for (genvar g = 0; g < SignalWidth; g++) begin : g_ch
      pulse_stretcher_ch #(
         .PulseWidth    (PulseWidth),
         .Retrigger     (Retrigger),
         .HoldoffCycles (HoldoffCycles)
      ) u_ch (
         .clock   (clock),
         .reset   (reset),
         .trig    (trig[g]),
         .q       (q[g]),
         .done    (done[g]),
         .dropped (dropped[g])
      );
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed timing scenarios plus randomized traffic against a
// timestamp-based reference model, over five differently-configured instances.
module tb_pulse_stretcher;

   localparam int NI = 5;
   localparam int PWS [NI] = '{4, 4, 8, 2, 1};
   localparam int RTS [NI] = '{1, 0, 1, 1, 0};
   localparam int HCS [NI] = '{2, 2, 0, 3, 0};
   localparam int NEG = -1000000;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] trig_v [NI];
   logic [3:0] q_v    [NI];
   logic [3:0] done_v [NI];
   logic [3:0] drop_v [NI];

   int checks   = 0;
   int failures = 0;

   // Model state: per channel, the edge that started the pulse and the edge at which it ends.
   int         edge_n = 0;
   int         s_e   [NI][4];
   int         end_e [NI][4];
   logic [3:0] exp_q    [NI];
   logic [3:0] exp_done [NI];
   logic [3:0] exp_drop [NI];

   always #5 clock = ~clock;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      pulse_stretcher #(
         .SignalWidth   (4),
         .PulseWidth    (PWS[g]),
         .Retrigger     (RTS[g]),
         .HoldoffCycles (HCS[g])
      ) u_dut (
         .clock   (clock),
         .reset   (reset),
         .trig    (trig_v[g]),
         .q       (q_v[g]),
         .done    (done_v[g]),
         .dropped (drop_v[g])
      );
   end

   task automatic step_model();
      edge_n++;
      for (int i = 0; i < NI; i++) begin
         for (int c = 0; c < 4; c++) begin
            bit t, act, hold;
            t = trig_v[i][c];
            exp_done[i][c] = 1'b0;
            exp_drop[i][c] = 1'b0;
            if (reset) begin
               s_e[i][c]   = NEG;
               end_e[i][c] = NEG;
            end else begin
               act  = (edge_n > s_e[i][c]) && (edge_n <= end_e[i][c]);
               hold = HOLD_EN && (edge_n > end_e[i][c]) && (edge_n <= end_e[i][c] + HCS[i]);
               if (act) begin
                  if (t && RTS[i] != 0) end_e[i][c] = edge_n + PWS[i];
                  else if (t)           exp_drop[i][c] = 1'b1;
                  if (edge_n == end_e[i][c]) exp_done[i][c] = 1'b1;
               end else if (hold) begin
                  if (t) exp_drop[i][c] = 1'b1;
               end else if (t) begin
                  s_e[i][c]   = edge_n;
                  end_e[i][c] = edge_n + PWS[i];
               end
            end
            exp_q[i][c] = (s_e[i][c] <= edge_n) && (edge_n < end_e[i][c]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      step_model();
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < NI; i++) trig_v[i] = 4'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NI; i++) trig_v[i] = 4'($urandom_range(1, 15));
         tick();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if ({q_v[i], done_v[i], drop_v[i]} !== 12'b0) begin
               failures++;
               $display("FAIL reset inst%0d: q=%b done=%b dropped=%b want all 0", i, q_v[i], done_v[i], drop_v[i]);
            end
         end
      end
      reset = 1'b0;
      idle(12);
   endtask

   task automatic test_single_pulse();
      logic [9:0] tp, qe, de, xe;
      tp = 10'b0000000001; qe = 10'b0000001111; de = 10'b0000010000; xe = 10'b0;
      idle(12);
      for (int j = 0; j < 10; j++) begin
         trig_v[0] = {3'b0, tp[j]};
         tick();
         checks++;
         if ({q_v[0][0], done_v[0][0], drop_v[0][0]} !== {qe[j], de[j], xe[j]}) begin
            failures++;
            $display("FAIL single_pulse cycle %0d: q/done/dropped=%b%b%b want %b%b%b",
                     j, q_v[0][0], done_v[0][0], drop_v[0][0], qe[j], de[j], xe[j]);
         end
      end
   endtask

   task automatic test_retrigger();
      logic [9:0] tp, qe, de, xe;
      tp = 10'b0000001001; qe = 10'b0001111111; de = 10'b0010000000; xe = 10'b0;
      idle(12);
      for (int j = 0; j < 10; j++) begin
         trig_v[0] = {3'b0, tp[j]};
         tick();
         checks++;
         if ({q_v[0][0], done_v[0][0], drop_v[0][0]} !== {qe[j], de[j], xe[j]}) begin
            failures++;
            $display("FAIL retrigger cycle %0d: q/done/dropped=%b%b%b want %b%b%b",
                     j, q_v[0][0], done_v[0][0], drop_v[0][0], qe[j], de[j], xe[j]);
         end
      end
   endtask

   task automatic test_no_retrigger();
      logic [9:0] tp, qe, de, xe;
      tp = 10'b0000010101; qe = 10'b0000001111; de = 10'b0000010000; xe = 10'b0000010100;
      idle(12);
      for (int j = 0; j < 10; j++) begin
         trig_v[1] = {3'b0, tp[j]};
         tick();
         checks++;
         if ({q_v[1][0], done_v[1][0], drop_v[1][0]} !== {qe[j], de[j], xe[j]}) begin
            failures++;
            $display("FAIL no_retrigger cycle %0d: q/done/dropped=%b%b%b want %b%b%b",
                     j, q_v[1][0], done_v[1][0], drop_v[1][0], qe[j], de[j], xe[j]);
         end
      end
   endtask

   task automatic test_holdoff();
      logic [9:0] tp, qe, de, xe;
      tp = 10'b0001001001;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
      qe = 10'b0011000011; de = 10'b0100000100; xe = 10'b0000001000;
`else
      qe = 10'b0011011011; de = 10'b0100100100; xe = 10'b0;
`endif
      idle(12);
      for (int j = 0; j < 10; j++) begin
         trig_v[3] = {3'b0, tp[j]};
         tick();
         checks++;
         if ({q_v[3][0], done_v[3][0], drop_v[3][0]} !== {qe[j], de[j], xe[j]}) begin
            failures++;
            $display("FAIL holdoff cycle %0d: q/done/dropped=%b%b%b want %b%b%b",
                     j, q_v[3][0], done_v[3][0], drop_v[3][0], qe[j], de[j], xe[j]);
         end
      end
   endtask

   task automatic test_pulse_width_one();
      logic [9:0] tp, qe, de, xe;
      tp = 10'b0000001011; qe = 10'b0000001001; de = 10'b0000010010; xe = 10'b0000000010;
      idle(12);
      for (int j = 0; j < 10; j++) begin
         trig_v[4] = {3'b0, tp[j]};
         tick();
         checks++;
         if ({q_v[4][0], done_v[4][0], drop_v[4][0]} !== {qe[j], de[j], xe[j]}) begin
            failures++;
            $display("FAIL pw1 cycle %0d: q/done/dropped=%b%b%b want %b%b%b",
                     j, q_v[4][0], done_v[4][0], drop_v[4][0], qe[j], de[j], xe[j]);
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      logic [3:0] qe;
      idle(12);
      for (int j = 0; j < 10; j++) begin
         trig_v[2] = (j == 0) ? 4'b0101 : 4'b0000;
         reset     = (j == 3);
         tick();
         qe = (j < 3) ? 4'b0101 : 4'b0000;
         checks++;
         if ({q_v[2], done_v[2], drop_v[2]} !== {qe, 8'b0}) begin
            failures++;
            $display("FAIL reset_mid_pulse cycle %0d: q=%b done=%b dropped=%b want q=%b done=0000 dropped=0000",
                     j, q_v[2], done_v[2], drop_v[2], qe);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_random();
      int dens [NI];
      idle(12);
      for (int k = 0; k < 1500; k++) begin
         if (k % 100 == 0)
            for (int i = 0; i < NI; i++) dens[i] = $urandom_range(5, 70);
         for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++)
               trig_v[i][c] = ($urandom_range(0, 99) < dens[i]);
         reset = ($urandom_range(0, 149) == 0);
         tick();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if ({q_v[i], done_v[i], drop_v[i]} !== {exp_q[i], exp_done[i], exp_drop[i]}) begin
               failures++;
               $display("FAIL random k=%0d inst%0d: q=%b done=%b dropped=%b want q=%b done=%b dropped=%b",
                        k, i, q_v[i], done_v[i], drop_v[i], exp_q[i], exp_done[i], exp_drop[i]);
            end
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         trig_v[i] = 4'b0;
         for (int c = 0; c < 4; c++) begin
            s_e[i][c]   = NEG;
            end_e[i][c] = NEG;
         end
      end
      test_reset();
      test_single_pulse();
      test_retrigger();
      test_no_retrigger();
      test_holdoff();
      test_pulse_width_one();
      test_reset_mid_pulse();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
